chained_shift_out: RTL and testbench

Parametrised serial output driver for a daisy-chain of latching shift registers (74HC595-style) feeding the clock's display and LED drivers. It captures a WIDTH×DEVICES-bit parallel word on a start strobe and shifts it out MSB- or LSB-first, paced by an external serial-clock strobe. It then pulses the storage latch once so every device in the chain updates simultaneously. It sits between the display formatting logic and the chip pins, and adds what the single-register shifter does not have: multi-device chaining, per-transfer bit order, an explicit latch phase and a done strobe.

---
 rtl/chained_shift_out.sv | 135 +++++++++++++
 tb/tb_chained_shift_out.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/chained_shift_out.sv
// Serial driver for a daisy-chain of latching shift registers (74HC595-style).
// Captures an N-bit word, shifts it out paced by i_clk_stb, then pulses the storage latch once.
module chained_shift_out #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEVICES = 2
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_clk_stb,
  input  logic                       i_start_stb,
  input  logic                       i_lsb_first,
  input  logic [WIDTH*DEVICES-1:0]   i_parallel_data,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_serial_data,
  output logic                       o_serial_clk,
  output logic                       o_serial_latch
);

  localparam int unsigned N    = WIDTH * DEVICES;
  localparam int unsigned CntW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StData, StClk, StLatch} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    shreg_q, shreg_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            lsb_q, lsb_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            sdata_q, sdata_d;
  logic            sclk_q, sclk_d;
  logic            latch_q, latch_d;
  logic            last_bit;

  assign last_bit = (cnt_q == CntW'(N - 1));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (i_start_stb) state_d = StData;
      StData:  if (i_clk_stb) state_d = StClk;
      StClk:   if (i_clk_stb) state_d = last_bit ? StLatch : StData;
      StLatch: if (i_clk_stb) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    lsb_d   = lsb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sdata_d = sdata_q;
    sclk_d  = sclk_q;
    latch_d = latch_q;
    unique case (state_q)
      StIdle: begin
        if (i_start_stb) begin
          shreg_d = i_parallel_data;
          lsb_d   = i_lsb_first;
          cnt_d   = '0;
          busy_d  = 1'b1;
          sdata_d = i_lsb_first ? i_parallel_data[0] : i_parallel_data[N-1];
        end
      end
      StData: begin
        if (i_clk_stb) sclk_d = 1'b1;
      end
      StClk: begin
        if (i_clk_stb) begin
          sclk_d = 1'b0;
          if (last_bit) begin
            latch_d = 1'b1;
          end else begin
            // Next bit is presented on the same edge the serial clock falls
            shreg_d = lsb_q ? (shreg_q >> 1) : (shreg_q << 1);
            sdata_d = lsb_q ? shreg_q[1] : shreg_q[N-2];
            cnt_d   = cnt_q + CntW'(1);
          end
        end
      end
      StLatch: begin
        if (i_clk_stb) begin
          latch_d = 1'b0;
          sdata_d = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      lsb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sdata_q <= 1'b0;
      sclk_q  <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      lsb_q   <= lsb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sdata_q <= sdata_d;
      sclk_q  <= sclk_d;
      latch_q <= latch_d;
    end
  end

  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_serial_data  = sdata_q;
  assign o_serial_clk   = sclk_q;
  assign o_serial_latch = latch_q;

endmodule

// File: tb/tb_chained_shift_out.sv
// Directed self-checking bench for chained_shift_out (WIDTH=8, DEVICES=2).
module tb_chained_shift_out;

  logic        i_clk;
  logic        i_reset;
  logic        i_clk_stb;
  logic        i_start_stb;
  logic        i_lsb_first;
  logic [15:0] i_parallel_data;
  logic        o_busy;
  logic        o_done;
  logic        o_serial_data;
  logic        o_serial_clk;
  logic        o_serial_latch;

  chained_shift_out #(
    .WIDTH   (8),
    .DEVICES (2)
  ) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_clk_stb       (i_clk_stb),
    .i_start_stb     (i_start_stb),
    .i_lsb_first     (i_lsb_first),
    .i_parallel_data (i_parallel_data),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_serial_data   (o_serial_data),
    .o_serial_clk    (o_serial_clk),
    .o_serial_latch  (o_serial_latch)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int nstb     = 0;

  // Monitor state, written only by the negedge monitor
  logic [15:0] cap = '0;
  int rises = 0;
  int latches = 0;
  int dones = 0;
  int done_at_stb = 0;
  logic sclk_prev = 1'b0;
  logic latch_prev = 1'b0;

  always @(negedge i_clk) begin
    if (o_serial_clk && !sclk_prev) begin
      cap = {cap[14:0], o_serial_data};
      rises = rises + 1;
    end
    if (o_serial_latch && !latch_prev) latches = latches + 1;
    if (o_done) begin
      dones = dones + 1;
      done_at_stb = nstb;
    end
    sclk_prev  = o_serial_clk;
    latch_prev = o_serial_latch;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_xfer(input logic [15:0] d, input logic lsb);
    i_parallel_data = d;
    i_lsb_first     = lsb;
    i_start_stb     = 1'b1;
    tick();
    i_start_stb     = 1'b0;
    // Inputs may change freely after acceptance
    i_parallel_data = ~d;
    i_lsb_first     = ~lsb;
  endtask

  task automatic strobe_one();
    i_clk_stb = 1'b1;
    nstb++;
    tick();
    i_clk_stb = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_busy"},  32'(o_busy), 32'd0);
    check({tag, "_done"},  32'(o_done), 32'd0);
    check({tag, "_sdata"}, 32'(o_serial_data), 32'd0);
    check({tag, "_sclk"},  32'(o_serial_clk), 32'd0);
    check({tag, "_latch"}, 32'(o_serial_latch), 32'd0);
  endtask

  // Runs a full 33-strobe transfer and checks the captured bit stream
  task automatic run_xfer(input string tag, input logic [15:0] d, input logic lsb,
                          input logic [15:0] exp_bits);
    int r0, l0, d0, s0;
    r0 = rises; l0 = latches; d0 = dones; s0 = nstb;
    start_xfer(d, lsb);
    check({tag, "_busy_rise"}, 32'(o_busy), 32'd1);
    repeat (33) strobe_one();
    check({tag, "_bits"},    32'(cap), 32'(exp_bits));
    check({tag, "_rises"},   32'(rises - r0), 32'd16);
    check({tag, "_latches"}, 32'(latches - l0), 32'd1);
    check({tag, "_dones"},   32'(dones - d0), 32'd1);
    check({tag, "_done_stb"}, 32'(done_at_stb - s0), 32'd33);
    check({tag, "_busy_end"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    int r0, l0, d0;
    i_reset = 1'b1;
    i_clk_stb = 1'b0;
    i_start_stb = 1'b0;
    i_lsb_first = 1'b0;
    i_parallel_data = '0;

    // Reset values
    repeat (2) tick();
    check_all_low("reset");
    i_reset = 1'b0;

    // Strobes with no start do nothing
    r0 = rises; l0 = latches; d0 = dones;
    repeat (10) strobe_one();
    check_all_low("idle_stb");
    check("idle_rises", 32'(rises - r0), 32'd0);
    check("idle_latches", 32'(latches - l0), 32'd0);
    check("idle_dones", 32'(dones - d0), 32'd0);

    run_xfer("msb", 16'hA5C3, 1'b0, 16'hA5C3);
    run_xfer("lsb", 16'hA5C3, 1'b1, 16'hC3A5);

    // Restart request during an active transfer is ignored
    r0 = rises; l0 = latches; d0 = dones;
    start_xfer(16'h0000, 1'b0);
    for (int i = 1; i <= 33; i++) begin
      i_clk_stb = 1'b1;
      nstb++;
      if (i == 5) begin
        i_start_stb = 1'b1;
        i_parallel_data = 16'hFFFF;
      end
      tick();
      i_clk_stb = 1'b0;
      i_start_stb = 1'b0;
      repeat (3) tick();
    end
    check("restart_bits", 32'(cap), 32'h0000);
    check("restart_rises", 32'(rises - r0), 32'd16);
    check("restart_latches", 32'(latches - l0), 32'd1);
    check("restart_dones", 32'(dones - d0), 32'd1);
    check("restart_busy_end", 32'(o_busy), 32'd0);

    // Back-to-back: start in the o_done cycle
    r0 = rises; d0 = dones;
    start_xfer(16'h8001, 1'b0);
    repeat (32) strobe_one();
    i_clk_stb = 1'b1;
    nstb++;
    tick();
    i_clk_stb = 1'b0;
    check("b2b_done_cycle", 32'(o_done), 32'd1);
    i_parallel_data = 16'h1234;
    i_lsb_first = 1'b0;
    i_start_stb = 1'b1;
    tick();
    i_start_stb = 1'b0;
    i_parallel_data = 16'hFFFF;
    check("b2b_busy_again", 32'(o_busy), 32'd1);
    check("b2b_first_bits", 32'(cap), 32'h8001);
    check("b2b_first_dones", 32'(dones - d0), 32'd1);
    r0 = rises; l0 = latches; d0 = dones;
    repeat (33) strobe_one();
    check("b2b_second_bits", 32'(cap), 32'h1234);
    check("b2b_second_rises", 32'(rises - r0), 32'd16);
    check("b2b_second_latches", 32'(latches - l0), 32'd1);
    check("b2b_second_dones", 32'(dones - d0), 32'd1);

    // Mid-shift reset: no latch pulse, then a normal transfer
    l0 = latches; d0 = dones;
    start_xfer(16'hA5C3, 1'b0);
    repeat (9) strobe_one();
    i_reset = 1'b1;
    tick();
    check_all_low("midrst");
    i_reset = 1'b0;
    repeat (3) strobe_one();
    check("midrst_latches", 32'(latches - l0), 32'd0);
    check("midrst_dones", 32'(dones - d0), 32'd0);
    check("midrst_busy_after", 32'(o_busy), 32'd0);
    run_xfer("post_rst", 16'h00FF, 1'b0, 16'h00FF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
